hdmi_packet_scheduler: RTL and testbench

// Per-slot scheduler for HDMI data-island packets. On each packet-slot strobe from the data-island timing logic,
// it picks the header type for the next 32-cycle packet: ACR, audio sample, AVI/Audio/SPD InfoFrame or NULL.
// It also pops audio samples and generates the sample-present and IEC60958 B (block start) flags.
// It sits between the audio sample buffer / clock-regen counter and the packet assembler feeding the TERC4 encoders.

---
 rtl/hdmi_pkg.sv | 16 +
 rtl/hdmi_iec_frame_counter.sv | 44 ++++
 rtl/hdmi_packet_scheduler.sv | 118 +++++++++++
 tb/tb_hdmi_packet_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI data-island packet scheduler.
// Packet header HB0 codes and IEC60958 block length default.
package hdmi_pkg;

  typedef enum logic [7:0] {
    PKT_NULL     = 8'h00,
    PKT_ACR      = 8'h01,
    PKT_AUDIO    = 8'h02,
    PKT_AVI      = 8'h82,
    PKT_SPD      = 8'h83,
    PKT_AUDIO_IF = 8'h84
  } packet_type_t;

  localparam int IEC_FRAME_LEN_DEFAULT = 192;

endpackage

// File: rtl/hdmi_iec_frame_counter.sv
// IEC60958 frame counter, modulo LEN, advanced by n per audio packet.
// Ports: clk_pixel, reset, advance, n -> cnt, b_flags (bit k: cnt+k hits block start).
module hdmi_iec_frame_counter
  import hdmi_pkg::*;
#(
  parameter int LEN = IEC_FRAME_LEN_DEFAULT,
  parameter int CW  = $clog2(LEN)
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic          advance,
  input  logic [2:0]    n,
  output logic [CW-1:0] cnt,
  output logic [3:0]    b_flags
);

  int sum;
  logic [CW-1:0] nxt;

  // cnt < LEN and k < 4, so (cnt+k) % LEN == 0
  // only when cnt+k is 0 or exactly LEN.
  always_comb begin
    b_flags = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      b_flags[k] = ((int'(cnt) + k) == 0) ||
                   ((int'(cnt) + k) == LEN);
    end
  end

  always_comb begin
    sum = int'(cnt) + int'(n);
    if (sum >= LEN) sum = sum - LEN;
    nxt = CW'(sum);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Per-slot HDMI data-island packet scheduler: ACR > audio > InfoFrames > NULL.
// Ports: clk_pixel, reset, packet_slot, frame_start, acr_request, audio_count -> audio_pop(_n), packet_type, sample_present, sample_b, slot_valid.
module hdmi_packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int         MAX_SAMPLES   = 4,
  parameter int         IEC_FRAME_LEN = IEC_FRAME_LEN_DEFAULT,
  parameter logic [2:0] INFOFRAME_EN  = 3'b111
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       packet_slot,
  input  logic       frame_start,
  input  logic       acr_request,
  input  logic [2:0] audio_count,
  output logic       audio_pop,
  output logic [2:0] audio_pop_n,
  output logic [7:0] packet_type,
  output logic [3:0] sample_present,
  output logic [3:0] sample_b,
  output logic       slot_valid
);

  localparam int CW = $clog2(IEC_FRAME_LEN);

  logic          acr_pend;
  logic [2:0]    if_pend;
  logic          acr_eff;
  logic [2:0]    if_eff;
  logic [2:0]    n;
  logic [3:0]    present;
  logic [3:0]    b_all;
  logic [CW-1:0] iec_cnt;
  logic          grant_audio;
  logic          acr_clr;
  logic [2:0]    if_clr;
  packet_type_t  sel;

  hdmi_iec_frame_counter #(
    .LEN (IEC_FRAME_LEN),
    .CW  (CW)
  ) u_iec (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .advance   (packet_slot & grant_audio),
    .n         (n),
    .cnt       (iec_cnt),
    .b_flags   (b_all)
  );

  // Same-cycle requests fold into the pending view so the
  // coincident slot can grant them.
  always_comb begin
    acr_eff = acr_pend | acr_request;
    if_eff  = if_pend | (frame_start ? INFOFRAME_EN : 3'b000);
    n = (audio_count > 3'(MAX_SAMPLES)) ?
        3'(MAX_SAMPLES) : audio_count;
    present = 4'((5'd1 << n) - 5'd1);
    sel = PKT_NULL;
    grant_audio = 1'b0;
    acr_clr = 1'b0;
    if_clr = 3'b000;
    priority case (1'b1)
      acr_eff: begin
        sel = PKT_ACR;
        acr_clr = 1'b1;
      end
      (audio_count != 3'd0): begin
        sel = PKT_AUDIO;
        grant_audio = 1'b1;
      end
      if_eff[0]: begin
        sel = PKT_AVI;
        if_clr = 3'b001;
      end
      if_eff[1]: begin
        sel = PKT_AUDIO_IF;
        if_clr = 3'b010;
      end
      if_eff[2]: begin
        sel = PKT_SPD;
        if_clr = 3'b100;
      end
      default: sel = PKT_NULL;
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      acr_pend       <= 1'b0;
      if_pend        <= 3'b000;
      slot_valid     <= 1'b0;
      audio_pop      <= 1'b0;
      audio_pop_n    <= 3'd0;
      packet_type    <= 8'h00;
      sample_present <= 4'd0;
      sample_b       <= 4'd0;
    end else begin
      slot_valid <= packet_slot;
      audio_pop  <= packet_slot & grant_audio;
      acr_pend   <= acr_eff & ~(packet_slot & acr_clr);
      if_pend    <= if_eff & ~(packet_slot ? if_clr : 3'b000);
      if (packet_slot) begin
        packet_type <= sel;
        if (grant_audio) begin
          audio_pop_n    <= n;
          sample_present <= present;
          sample_b       <= present & b_all;
        end else begin
          audio_pop_n    <= 3'd0;
          sample_present <= 4'd0;
          sample_b       <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed self-checking bench for hdmi_packet_scheduler.
// Drives on negedge, samples outputs on the following negedge.
module tb_hdmi_packet_scheduler;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic       packet_slot = 1'b0;
  logic       frame_start = 1'b0;
  logic       acr_request = 1'b0;
  logic [2:0] audio_count = 3'd0;
  logic       audio_pop;
  logic [2:0] audio_pop_n;
  logic [7:0] packet_type;
  logic [3:0] sample_present;
  logic [3:0] sample_b;
  logic       slot_valid;

  int checks = 0;
  int errors = 0;

  hdmi_packet_scheduler dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .packet_slot    (packet_slot),
    .frame_start    (frame_start),
    .acr_request    (acr_request),
    .audio_count    (audio_count),
    .audio_pop      (audio_pop),
    .audio_pop_n    (audio_pop_n),
    .packet_type    (packet_type),
    .sample_present (sample_present),
    .sample_b       (sample_b),
    .slot_valid     (slot_valid)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One strobe; returns at the negedge after the decision edge.
  task automatic slot(input logic acr, input logic fs,
                      input logic [2:0] cnt);
    @(negedge clk_pixel);
    packet_slot = 1'b1;
    acr_request = acr;
    frame_start = fs;
    audio_count = cnt;
    @(negedge clk_pixel);
    packet_slot = 1'b0;
    acr_request = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pkt(input string tag, input logic [7:0] ty,
                     input logic pop, input logic [2:0] pn,
                     input logic [3:0] pr);
    chk({tag, ".valid"}, 32'(slot_valid), 32'd1);
    chk({tag, ".type"}, 32'(packet_type), 32'(ty));
    chk({tag, ".pop"}, 32'(audio_pop), 32'(pop));
    chk({tag, ".pop_n"}, 32'(audio_pop_n), 32'(pn));
    chk({tag, ".present"}, 32'(sample_present), 32'(pr));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.valid", 32'(slot_valid), 32'd0);
    chk("rst.type", 32'(packet_type), 32'h00);
    chk("rst.pop", 32'(audio_pop), 32'd0);
    chk("rst.pop_n", 32'(audio_pop_n), 32'd0);
    chk("rst.present", 32'(sample_present), 32'd0);
    chk("rst.b", 32'(sample_b), 32'd0);
    @(negedge clk_pixel);
    reset = 1'b0;

    // Idle slot -> NULL
    slot(1'b0, 1'b0, 3'd0);
    pkt("idle", 8'h00, 1'b0, 3'd0, 4'h0);
    @(negedge clk_pixel);
    chk("idle.valid_drop", 32'(slot_valid), 32'd0);

    // ACR + audio + frame together
    slot(1'b1, 1'b1, 3'd4);
    pkt("mix1", 8'h01, 1'b0, 3'd0, 4'h0);
    slot(1'b0, 1'b0, 3'd4);
    pkt("mix2", 8'h02, 1'b1, 3'd4, 4'hF);
    chk("mix2.b", 32'(sample_b), 32'h1);
    @(negedge clk_pixel);
    chk("mix2.pop_drop", 32'(audio_pop), 32'd0);
    chk("mix2.hold", 32'(packet_type), 32'h02);
    slot(1'b0, 1'b0, 3'd0);
    pkt("mix3", 8'h82, 1'b0, 3'd0, 4'h0);
    slot(1'b0, 1'b0, 3'd0);
    pkt("mix4", 8'h84, 1'b0, 3'd0, 4'h0);
    slot(1'b0, 1'b0, 3'd0);
    pkt("mix5", 8'h83, 1'b0, 3'd0, 4'h0);
    slot(1'b0, 1'b0, 3'd0);
    pkt("mix6", 8'h00, 1'b0, 3'd0, 4'h0);

    // ACR coincident with slot, then not repeated
    slot(1'b1, 1'b0, 3'd0);
    pkt("acr_same", 8'h01, 1'b0, 3'd0, 4'h0);
    slot(1'b0, 1'b0, 3'd0);
    pkt("acr_next", 8'h00, 1'b0, 3'd0, 4'h0);

    // Double frame_start arms only one copy each
    @(negedge clk_pixel);
    frame_start = 1'b1;
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    frame_start = 1'b0;
    slot(1'b0, 1'b0, 3'd0);
    chk("rearm.avi", 32'(packet_type), 32'h82);
    slot(1'b0, 1'b0, 3'd0);
    chk("rearm.aif", 32'(packet_type), 32'h84);
    slot(1'b0, 1'b0, 3'd0);
    chk("rearm.spd", 32'(packet_type), 32'h83);
    slot(1'b0, 1'b0, 3'd0);
    chk("rearm.null", 32'(packet_type), 32'h00);

    // Fresh iec_cnt = 0
    @(negedge clk_pixel);
    reset = 1'b1;
    @(negedge clk_pixel);
    reset = 1'b0;

    // 48 packets of 4: only first has B
    for (int i = 0; i < 48; i++) begin
      slot(1'b0, 1'b0, 3'd4);
      chk($sformatf("blk.b%0d", i), 32'(sample_b),
          (i == 0) ? 32'h1 : 32'h0);
    end
    slot(1'b0, 1'b0, 3'd4);
    chk("blk.b48", 32'(sample_b), 32'h1);
    // iec_cnt = 4; advance 184 -> 188, then 2 -> 190
    for (int i = 0; i < 46; i++) slot(1'b0, 1'b0, 3'd4);
    slot(1'b0, 1'b0, 3'd2);
    pkt("n2", 8'h02, 1'b1, 3'd2, 4'h3);
    chk("n2.b", 32'(sample_b), 32'h0);
    chk("iec.190", 32'(dut.iec_cnt), 32'd190);
    slot(1'b0, 1'b0, 3'd4);
    chk("wrap.b", 32'(sample_b), 32'h4);
    chk("wrap.cnt", 32'(dut.iec_cnt), 32'd2);

    // Sample count clamping
    slot(1'b0, 1'b0, 3'd3);
    pkt("n3", 8'h02, 1'b1, 3'd3, 4'h7);
    slot(1'b0, 1'b0, 3'd7);
    pkt("n7", 8'h02, 1'b1, 3'd4, 4'hF);
    chk("n7.cnt", 32'(dut.iec_cnt), 32'd9);

    // Arm pendings, then reset during a slot
    @(negedge clk_pixel);
    acr_request = 1'b1;
    frame_start = 1'b1;
    @(negedge clk_pixel);
    acr_request = 1'b0;
    frame_start = 1'b0;
    packet_slot = 1'b1;
    audio_count = 3'd4;
    #2 reset = 1'b1;
    @(posedge clk_pixel);
    #1;
    chk("abort.valid", 32'(slot_valid), 32'd0);
    chk("abort.pop", 32'(audio_pop), 32'd0);
    @(negedge clk_pixel);
    packet_slot = 1'b0;
    audio_count = 3'd0;
    reset = 1'b0;
    chk("abort.cnt", 32'(dut.iec_cnt), 32'd0);
    slot(1'b0, 1'b0, 3'd0);
    pkt("abort.null", 8'h00, 1'b0, 3'd0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
